// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: EX-stage launcher for the radix-2 divider and owner of HI/LO.
// Define DIV_ZERO_BYPASS_EN to resolve zero divisors in one cycle without the divider.
module div_hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_div_valid,
    input  logic        ex_div_sign,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    output logic        stall_ex,
    output logic        div_rst,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_sign,
    output logic        div_opn_valid,
    input  logic        div_res_valid,
    output logic        div_res_ready,
    input  logic [63:0] div_result,
    input  logic        wb_hi_we,
    input  logic        wb_lo_we,
    input  logic [31:0] wb_wdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        launch;
    logic        zero_commit;
    logic        div_commit;

    always_comb begin
        launch = (state_q == IDLE) & ex_div_valid & ~flush;
`ifdef DIV_ZERO_BYPASS_EN
        zero_commit = launch & (ex_rt == 32'd0);
`else
        zero_commit = 1'b0;
`endif
        div_commit = (state_q == WAIT) & div_res_valid & ~flush;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        unique case (state_q)
            IDLE: begin
                if (zero_commit) begin
                    state_d = DONE;
                end else if (launch) begin
                    state_d = REQ;
                    a_d     = ex_rs;
                    b_d     = ex_rt;
                    sign_d  = ex_div_sign;
                end
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                if (div_res_valid) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // The divide is younger than any WB move, so its commit overrides it.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (wb_hi_we) begin
            hi_d = wb_wdata;
        end
        if (wb_lo_we) begin
            lo_d = wb_wdata;
        end
        if (div_commit) begin
            hi_d = div_result[63:32];
            lo_d = div_result[31:0];
        end
        if (zero_commit) begin
            hi_d = ex_rs;
            lo_d = 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign stall_ex      = launch | (state_q == REQ) | (state_q == WAIT);
    assign div_rst       = rst | flush;
    assign div_a         = a_q;
    assign div_b         = b_q;
    assign div_sign      = sign_q;
    assign div_opn_valid = (state_q == REQ);
    assign div_res_ready = (state_q == WAIT);
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl: randomized scoreboard bench for div_hilo_ctrl with a 33-cycle divider model.
// Honours DIV_ZERO_BYPASS_EN when the bundle is built with it.
module tb_div_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_div_valid;
    logic        ex_div_sign;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic        stall_ex;
    logic        div_rst;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_sign;
    logic        div_opn_valid;
    logic        div_res_valid;
    logic        div_res_ready;
    logic [63:0] div_result;
    logic        wb_hi_we;
    logic        wb_lo_we;
    logic [31:0] wb_wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    div_hilo_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ex_div_valid  (ex_div_valid),
        .ex_div_sign   (ex_div_sign),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .stall_ex      (stall_ex),
        .div_rst       (div_rst),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_sign      (div_sign),
        .div_opn_valid (div_opn_valid),
        .div_res_valid (div_res_valid),
        .div_res_ready (div_res_ready),
        .div_result    (div_result),
        .wb_hi_we      (wb_hi_we),
        .wb_lo_we      (wb_lo_we),
        .wb_wdata      (wb_wdata),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        int          opn;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
    } dexp_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } wexp_t;

    dexp_t       dq[$];
    wexp_t       wq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    function automatic logic is_bypass(input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
        return (b == 32'd0);
`else
        return (b == 32'd0) & 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Divider stand-in: result appears 33 cycles after the operand strobe.
    logic busy;
    int   dcnt;
    always @(posedge clk) begin
        if (div_rst) begin
            busy          <= 1'b0;
            dcnt          <= 0;
            div_res_valid <= 1'b0;
        end else if (div_opn_valid && !busy) begin
            busy       <= 1'b1;
            dcnt       <= 0;
            div_result <= ref_div(div_a, div_b, div_sign);
        end else if (busy) begin
            if (div_res_valid) begin
                if (div_res_ready) begin
                    div_res_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            end else if (dcnt == 31) begin
                div_res_valid <= 1'b1;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    initial begin : monitor
        int          run;
        int          opn;
        int          opn_at;
        logic        wb_prev;
        logic [31:0] cap_a;
        logic [31:0] cap_b;
        logic        cap_s;
        dexp_t       d;
        wexp_t       w;
        run = 0;
        opn = 0;
        opn_at = -1;
        wb_prev = 1'b0;
        cap_a = '0;
        cap_b = '0;
        cap_s = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
                opn = 0;
                wb_prev = 1'b0;
            end else begin
                if (wb_prev) begin
                    if (wq.size() == 0) begin
                        chk("wb_unexpected", 1, 0);
                    end else begin
                        w = wq.pop_front();
                        chk("wb_hi", hi_o, w.hi);
                        chk("wb_lo", lo_o, w.lo);
                    end
                end
                if (flush) chk("div_rst_on_flush", div_rst, 1);
                if (div_opn_valid) begin
                    opn++;
                    opn_at = run;
                    cap_a = div_a;
                    cap_b = div_b;
                    cap_s = div_sign;
                end
                if (stall_ex) begin
                    run++;
                end else if (run > 0) begin
                    if (dq.size() == 0) begin
                        chk("div_unexpected", 1, 0);
                    end else begin
                        d = dq.pop_front();
                        chk("stall_len", run, d.len);
                        chk("opn_pulses", opn, d.opn);
                        if (d.opn == 1) begin
                            chk("opn_cycle", opn_at, 1);
                            chk("div_ops", {cap_s, cap_a, cap_b}, {d.s, d.a, d.b});
                        end
                        chk("div_hi", hi_o, d.hi);
                        chk("div_lo", lo_o, d.lo);
                    end
                    run = 0;
                    opn = 0;
                end
                wb_prev = wb_hi_we | wb_lo_we;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_mt(input logic mhi, input logic mlo, input logic [31:0] md);
        wexp_t w;
        if (mhi) ref_hi = md;
        if (mlo) ref_lo = md;
        w.hi = ref_hi;
        w.lo = ref_lo;
        wq.push_back(w);
        wb_hi_we = mhi;
        wb_lo_we = mlo;
        wb_wdata = md;
        @(posedge clk);
        #1;
        wb_hi_we = 1'b0;
        wb_lo_we = 1'b0;
    endtask

    // flush_at/mt_at are cycle offsets from the first EX cycle; -1 disables.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int flush_at, input int mt_at,
                          input logic mhi, input logic mlo, input logic [31:0] md);
        dexp_t       d;
        wexp_t       w;
        logic [63:0] res;
        logic        bz;
        int          commit_c;
        int          c;
        logic        st;
        logic [31:0] nh;
        logic [31:0] nl;
        res = ref_div(a, b, s);
        bz = is_bypass(b);
        commit_c = bz ? 0 : 34;
        d.a = a;
        d.b = b;
        d.s = s;
        d.opn = bz ? 0 : 1;
        if (flush_at > 0) begin
            d.len = flush_at + 1;
            d.hi = ref_hi;
            d.lo = ref_lo;
        end else begin
            d.len = commit_c + 1;
            d.hi = res[63:32];
            d.lo = res[31:0];
        end
        dq.push_back(d);
        nh = res[63:32];
        nl = res[31:0];
        if (mt_at >= 0 && mt_at != commit_c) begin
            if (mt_at < commit_c) begin
                nh = ref_hi;
                nl = ref_lo;
            end
            if (mhi) nh = md;
            if (mlo) nl = md;
        end
        if (mt_at >= 0) begin
            w.hi = nh;
            w.lo = nl;
            wq.push_back(w);
        end
        if (flush_at <= 0) begin
            if (mt_at == commit_c + 1) begin
                ref_hi = nh;
                ref_lo = nl;
            end else begin
                ref_hi = res[63:32];
                ref_lo = res[31:0];
            end
        end
        ex_div_valid = 1'b1;
        ex_div_sign = s;
        ex_rs = a;
        ex_rt = b;
        c = 0;
        forever begin
            flush = (c == flush_at);
            wb_hi_we = (c == mt_at) & mhi;
            wb_lo_we = (c == mt_at) & mlo;
            wb_wdata = md;
            @(negedge clk);
            st = stall_ex;
            @(posedge clk);
            #1;
            flush = 1'b0;
            wb_hi_we = 1'b0;
            wb_lo_we = 1'b0;
            if (c == flush_at || !st) break;
            c++;
            if (c > 60) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout cycles=%0d required<=%0d", c, commit_c + 1);
                break;
            end
        end
        ex_div_valid = 1'b0;
        if (flush_at > 0) idle(1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          cc;
        int          fa;
        int          ma;
        logic        hw;
        logic        lw;
        rst = 1'b1;
        flush = 1'b0;
        ex_div_valid = 1'b0;
        ex_div_sign = 1'b0;
        ex_rs = '0;
        ex_rt = '0;
        wb_hi_we = 1'b0;
        wb_lo_we = 1'b0;
        wb_wdata = '0;
        idle(3);
        @(negedge clk);
        chk("rst_div_rst", div_rst, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_outs", {stall_ex, div_rst, div_opn_valid, div_res_ready, div_sign}, 0);
        chk("rst_ops", {div_a, div_b}, 0);
        @(posedge clk);
        #1;

        do_div(32'd100, 32'd7, 1'b0, -1, -1, 1'b0, 1'b0, 32'd0);
        idle(1);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1, 1'b0, 1'b0, 32'd0);
        do_mt(1'b1, 1'b1, 32'h0000_5566);
        do_div(32'd200, 32'd3, 1'b0, 20, -1, 1'b0, 1'b0, 32'd0);
        do_div(32'h1234_5678, 32'd77, 1'b1, 34, -1, 1'b0, 1'b0, 32'd0);
        do_div(32'd9, 32'd4, 1'b0, -1, 34, 1'b1, 1'b0, 32'h0000_1234);
        do_div(32'd9, 32'd4, 1'b0, -1, 10, 1'b0, 1'b1, 32'h0000_AAAA);
        do_div(32'd5, 32'd0, 1'b0, -1, -1, 1'b0, 1'b0, 32'd0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                hw = 1'($urandom_range(0, 1));
                lw = !hw | 1'($urandom_range(0, 1));
                do_mt(hw, lw, $urandom);
            end else begin
                a = $urandom;
                b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                s = 1'($urandom_range(0, 1));
                cc = is_bypass(b) ? 0 : 34;
                fa = -1;
                ma = -1;
                case ($urandom_range(0, 3))
                    0: if (!is_bypass(b)) fa = $urandom_range(1, 34);
                    1: ma = $urandom_range(0, cc + 1);
                    default: ;
                endcase
                hw = 1'($urandom_range(0, 1));
                lw = !hw | 1'($urandom_range(0, 1));
                do_div(a, b, s, fa, ma, hw, lw, $urandom);
            end
            idle($urandom_range(0, 2));
        end

        idle(5);
        chk("div_q_drained", dq.size(), 0);
        chk("wb_q_drained", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_hilo_ctrl.md
# div_hilo_ctrl

Execute-stage controller that sits directly upstream of the radix-2 divider and downstream consumer of its result. It launches DIV/DIVU operations from EX, holds the pipeline while the divider runs, and commits {remainder, quotient} into the HI/LO architectural registers. It also services MTHI/MTLO writes from WB and aborts in-flight divisions on exception flush.

## Interface
- No parameters; all datapaths fixed at 32 bits (HI/LO) and 64 bits (divider result).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception flush; kills the in-flight divide, no HI/LO write
- ex_div_valid  in  1  DIV/DIVU present in EX
- ex_div_sign  in  1  1 = DIV (signed), 0 = DIVU
- ex_rs  in  32  dividend
- ex_rt  in  32  divisor
- stall_ex  out  1  hold EX and earlier stages
- div_rst  out  1  divider reset = rst | flush (combinational)
- div_a, div_b  out  32  latched dividend/divisor to divider
- div_sign  out  1  latched sign to divider
- div_opn_valid  out  1  operand strobe, one-way (divider always accepts when idle)
- div_res_valid  in  1  divider result ready
- div_res_ready  out  1  controller accepts result
- div_result  in  64  {remainder[63:32], quotient[31:0]}
- wb_hi_we, wb_lo_we  in  1  MTHI/MTLO write enables
- wb_wdata  in  32  MTHI/MTLO data
- hi_o, lo_o  out  32  current HI/LO register values

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset: state=IDLE; all outputs 0; hi_o=lo_o=0; operand latches 0.
- IDLE: if ex_div_valid & ~flush, latch ex_rs/ex_rt/ex_div_sign into div_a/div_b/div_sign and go to REQ.
- REQ: div_opn_valid=1 for exactly this cycle, then go to WAIT.
- WAIT: div_res_ready=1. On div_res_valid, at the edge: HI<=div_result[63:32], LO<=div_result[31:0]; go to DONE.
- DONE: lasts one cycle with stall_ex=0. ex_div_valid is ignored here because it belongs to the departing instruction. Then go to IDLE.
- stall_ex = (IDLE & ex_div_valid & ~flush) | REQ | WAIT.
- flush in any state: at the edge go to IDLE. div_rst is high this cycle. There is no HI/LO write from the divider, even if div_res_valid arrives in the same cycle.
- MTHI/MTLO: write HI/LO at the edge.
  - A simultaneous divider commit wins, because the divide is the younger instruction.
  - A WB write while in REQ or WAIT still updates HI/LO immediately.
- hi_o/lo_o are the register outputs; there is no same-cycle bypass.
- rst overrides everything.

## Timing
- ex_div_valid first seen in IDLE at cycle t; REQ at t+1; divider accepts at the end of t+1.
- Divider res_valid rises at t+34, and HI/LO are written at the end of t+34.
- DONE at t+35 with stall_ex=0. Total stall is 35 cycles (t..t+34).
- div_res_ready is held high throughout WAIT, so the result handshake completes in the cycle res_valid rises.
- Back-to-back DIVs: a second DIV can be accepted in IDLE at t+36 at the earliest.

## Configuration
- DIV_ZERO_BYPASS_EN defined:
  - In IDLE with ex_div_valid & ex_rt==0, the divider is not launched and div_opn_valid stays 0.
  - At that edge HI<=ex_rs and LO<=32'hFFFF_FFFF; go directly to DONE. Stall is 1 cycle.
  - flush in that cycle suppresses the write.
- Undefined: zero divisors take the normal 35-cycle path, and HI/LO receive whatever the divider produces.

## Test plan
- DIVU 100/7 -> div_opn_valid single pulse at t+1; stall_ex high t..t+34; HI=2, LO=14 visible at t+35.
- DIV -7/2 (0xFFFFFFF9/2) -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- flush at t+20 during WAIT -> div_rst high one cycle; state IDLE; HI/LO unchanged; stall_ex low next cycle.
- flush in the same cycle as div_res_valid -> no HI/LO write.
- MTHI 0x1234 in WB on the divider-commit edge of DIVU 9/4 -> HI=1 (divider wins), LO=2. MTLO 0xAAAA at t+10 -> lo_o=0xAAAA until commit overwrites it.
- DIVU 5/0 with DIV_ZERO_BYPASS_EN -> no div_opn_valid; 1-cycle stall; HI=5, LO=0xFFFFFFFF. Without the macro -> 35-cycle stall.
